// File: rtl/axis_stream_arbiter.sv
// axis_stream_arbiter
// Two-source, packet-granular round-robin arbiter in front of the AXIS data
// transmitter. The owning source is passed through combinationally, and packets
// are never interleaved. A packet is cut at MAX_BEATS; any remaining beats of
// that source are arbitrated again as a new packet. A completed-packet counter
// drives a fixed-length interrupt pulse toward the read interrupt generator.
module axis_stream_arbiter #(
    parameter int AXIS_DATA_WIDTH = 256,
    parameter int MAX_BEATS       = 400,
    parameter int BEAT_CNT_WIDTH  = 9,
    parameter int INTR_PKTS       = 1,
    parameter int INTR_PULSE_LEN  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s0_transmit_vld,
    input  logic [AXIS_DATA_WIDTH-1:0] s0_transmit_data,
    input  logic                       s0_transmit_last,
    output logic                       s0_transmit_rdy,
    input  logic                       s1_transmit_vld,
    input  logic [AXIS_DATA_WIDTH-1:0] s1_transmit_data,
    input  logic                       s1_transmit_last,
    output logic                       s1_transmit_rdy,
    output logic                       m_transmit_vld,
    output logic [AXIS_DATA_WIDTH-1:0] m_transmit_data,
    output logic                       m_transmit_last,
    input  logic                       m_transmit_rdy,
    output logic                       read_start_intr,
    output logic                       grant_id,
    output logic                       busy,
    output logic [15:0]                pkt_cnt,
    output logic                       err_trunc
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    localparam int INTR_CNT_W  = (INTR_PKTS > 1) ? $clog2(INTR_PKTS) : 1;
    localparam int PULSE_CNT_W = $clog2(INTR_PULSE_LEN + 1);

    logic [1:0]                state_q, state_d;
    logic                      last_grant_q, last_grant_d;
    logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [15:0]               pkt_cnt_q, pkt_cnt_d;
    logic                      err_trunc_q, err_trunc_d;
    logic [INTR_CNT_W-1:0]     intr_cnt_q, intr_cnt_d;
    logic [PULSE_CNT_W-1:0]    pulse_cnt_q, pulse_cnt_d;

    // Sources gathered into arrays so the per-source logic is written once
    logic [1:0]                 src_vld;
    logic [1:0]                 src_last;
    logic [1:0]                 src_rdy;
    logic [AXIS_DATA_WIDTH-1:0] src_data [2];

    logic cur;         // index of the owning source while granted
    logic sel0;        // IDLE arbitration result for source 0
    logic sel1;        // IDLE arbitration result for source 1
    logic force_last;  // this beat reaches the packet length cap
    logic beat;        // a beat is transferred this cycle
    logic trig;        // a packet completion that fires an interrupt

    assign src_vld     = {s1_transmit_vld, s0_transmit_vld};
    assign src_last    = {s1_transmit_last, s0_transmit_last};
    assign src_data[0] = s0_transmit_data;
    assign src_data[1] = s1_transmit_data;

    // Each source sees the transmitter's ready only while it owns the port
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src_rdy
            localparam logic [1:0] GRANT_ST = 2'(gi + 1);
            assign src_rdy[gi] = (state_q == GRANT_ST) && m_transmit_rdy;
        end
    endgenerate

    assign s0_transmit_rdy = src_rdy[0];
    assign s1_transmit_rdy = src_rdy[1];

    assign cur        = (state_q == ST_GRANT1);
    assign force_last = (beat_cnt_q == BEAT_CNT_WIDTH'(MAX_BEATS - 1));
    // On a tie, the source that did not win last time gets the grant
    assign sel0       = s0_transmit_vld && (!s1_transmit_vld || last_grant_q);
    assign sel1       = s1_transmit_vld && (!s0_transmit_vld || !last_grant_q);

    assign grant_id        = cur;
    assign busy            = (state_q != ST_IDLE);
    assign pkt_cnt         = pkt_cnt_q;
    assign err_trunc       = err_trunc_q;
    assign read_start_intr = (pulse_cnt_q != '0);

    // Arbitration FSM, pass-through mux, packet accounting and interrupt pulse
    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        beat_cnt_d      = beat_cnt_q;
        pkt_cnt_d       = pkt_cnt_q;
        err_trunc_d     = err_trunc_q;
        intr_cnt_d      = intr_cnt_q;
        pulse_cnt_d     = pulse_cnt_q;
        trig            = 1'b0;
        beat            = 1'b0;
        m_transmit_vld  = 1'b0;
        m_transmit_data = '0;
        m_transmit_last = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sel0) begin
                    state_d      = ST_GRANT0;
                    last_grant_d = 1'b0;
                end else if (sel1) begin
                    state_d      = ST_GRANT1;
                    last_grant_d = 1'b1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                m_transmit_vld  = src_vld[cur];
                m_transmit_data = src_data[cur];
                m_transmit_last = src_last[cur] | force_last;
                beat            = src_vld[cur] & m_transmit_rdy;
                if (beat) begin
                    if (m_transmit_last) begin
                        state_d    = ST_IDLE;
                        beat_cnt_d = '0;
                        pkt_cnt_d  = pkt_cnt_q + 16'd1;
                        if (!src_last[cur]) begin
                            err_trunc_d = 1'b1;
                        end
                        if (intr_cnt_q == INTR_CNT_W'(INTR_PKTS - 1)) begin
                            intr_cnt_d = '0;
                            trig       = 1'b1;
                        end else begin
                            intr_cnt_d = intr_cnt_q + 1'b1;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new trigger reloads the full pulse length, even mid-pulse
        if (trig) begin
            pulse_cnt_d = PULSE_CNT_W'(INTR_PULSE_LEN);
        end else if (pulse_cnt_q != '0) begin
            pulse_cnt_d = pulse_cnt_q - 1'b1;
        end
    end

    // State registers; reset discards any partial packet immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
            pkt_cnt_q    <= '0;
            err_trunc_q  <= 1'b0;
            intr_cnt_q   <= '0;
            pulse_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            pkt_cnt_q    <= pkt_cnt_d;
            err_trunc_q  <= err_trunc_d;
            intr_cnt_q   <= intr_cnt_d;
            pulse_cnt_q  <= pulse_cnt_d;
        end
    end

endmodule
